cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/lc3b_types.sv | 31 +++
 rtl/cache_arbiter.sv | 157 +++++++++++++++
 tb/tb_cache_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, cache line, and the memory arbiter's
// state/grant encodings plus a saturating counter helper.
package lc3b_types;

    localparam int WORD_W   = 16;
    localparam int C_LINE_W = 128;

    typedef logic [WORD_W-1:0]   lc3b_word;
    typedef logic [C_LINE_W-1:0] lc3b_c_line;

    // IDLE is encoded as zero so the debug state reads 0 out of reset.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

    localparam logic [15:0] GRANT_CNT_MAX = 16'hFFFF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == GRANT_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Arbiter between an I-cache and a D-cache sharing one physical-memory port.
// One transaction at a time: IDLE picks a requester, SERVE_x holds registered
// pmem strobes/address/wdata until pmem_resp, RELEASE spends one dead cycle so
// a request still held across the response edge is not granted twice.
//
// Handshake: a requester raises its read/write and holds it until its x_resp
// strobe; x_resp is a single-cycle pulse, combinational from pmem_resp, and
// x_rdata carries pmem_rdata only while x_resp is high (zero otherwise).
// On the memory side pmem_read/pmem_write stay high with stable address and
// wdata until the cycle pmem_resp is seen; pmem_resp outside SERVE_x is ignored.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic [15:0]       i_grants,
    output logic [15:0]       d_grants,

    output arb_state_t        dbg_state
);

    arb_state_t        state_q;
    arb_grant_t        last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [15:0]       i_grants_q;
    logic [15:0]       d_grants_q;

    logic [15:0]       i_grants_d;
    logic [15:0]       d_grants_d;

    logic              i_req;
    logic              d_req;
    logic              contested;
    logic              pick_i;
    logic              pick_d;

    assign i_req     = i_read;
    assign d_req     = d_read | d_write;
    assign contested = i_req & d_req;

    assign i_grants_d = sat_inc(i_grants_q);
    assign d_grants_d = sat_inc(d_grants_q);

    // Arbitration decision, only meaningful in IDLE. On a tie the side that
    // lost the previous tie wins; uncontested grants leave the history alone.
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (state_q == IDLE) begin
            if (contested) begin
                pick_d = (last_grant_q == GRANT_I);
                pick_i = (last_grant_q == GRANT_D);
            end else begin
                pick_d = d_req;
                pick_i = i_req;
            end
        end
    end

    // Main FSM: captures the granted request and owns every registered output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_grants_q   <= '0;
            d_grants_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q      <= SERVE_D;
                        addr_q       <= d_address;
                        wdata_q      <= d_wdata;
                        // A write flag wins even if d_read is also high.
                        pmem_write_q <= d_write;
                        pmem_read_q  <= ~d_write;
                        d_grants_q   <= d_grants_d;
                        if (contested) begin
                            last_grant_q <= GRANT_D;
                        end
                    end else if (pick_i) begin
                        state_q      <= SERVE_I;
                        addr_q       <= i_address;
                        wdata_q      <= '0;
                        pmem_write_q <= 1'b0;
                        pmem_read_q  <= 1'b1;
                        i_grants_q   <= i_grants_d;
                        if (contested) begin
                            last_grant_q <= GRANT_I;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q      <= RELEASE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Response steering: a single-cycle strobe to whichever cache is being
    // served; gated by rst_n so nothing reaches a cache while reset is low.
    always_comb begin
        i_resp  = rst_n & (state_q == SERVE_I) & pmem_resp;
        d_resp  = rst_n & (state_q == SERVE_D) & pmem_resp;
        i_rdata = i_resp ? pmem_rdata : '0;
        d_rdata = d_resp ? pmem_rdata : '0;
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_grants     = i_grants_q;
    assign d_grants     = d_grants_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized single and
// contended transactions. A memory model answers pmem requests with random
// latency; expected pmem requests and cache responses are queued by the
// stimulus and consumed by independent monitor processes.
module tb_cache_arbiter;
    import lc3b_types::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read;
    logic [15:0]  i_address;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  i_grants;
    logic [15:0]  d_grants;
    arb_state_t   dbg_state;

    cache_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grants(i_grants), .d_grants(d_grants), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Expected pmem request words {read, write, addr, wdata-if-write},
    // the requester behind each (1 = D), and expected responses {is_d, rdata}.
    logic [145:0] exp_pm_q[$];
    logic         exp_who_q[$];
    logic [128:0] exp_rsp_q[$];

    // Memory model controls
    int           mem_lat   = 0;      // 0 = random 1..4 cycles
    logic         use_fixed = 1'b0;
    logic [127:0] fixed_rdata = '0;
    logic         stray_req = 1'b0;

    // Reference model of grant bookkeeping
    int   model_ic   = 0;
    int   model_dc   = 0;
    logic model_tie_d = 1'b0;         // 1 when D won the last contested grant

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [145:0] pm_word(input logic w, input logic [15:0] a, input logic [127:0] d);
        return {~w, w, a, (w ? d : 128'h0)};
    endfunction

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory model: checks each new request against the expected queue,
    // checks it stays stable, and answers after the chosen latency.
    logic         mem_busy = 1'b0;
    int           mem_cnt;
    int           mem_lat_cur;
    logic [145:0] mem_raw;
    logic         mem_who;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mem_busy   = 1'b0;
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
        end else if (pmem_resp) begin
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            mem_busy   = 1'b0;
            check("release_strobes", 160'({pmem_read, pmem_write}), 160'(2'b00));
        end else if (pmem_read || pmem_write) begin
            if (!mem_busy) begin
                logic [145:0] cur_m;
                mem_busy = 1'b1;
                mem_cnt  = 0;
                mem_raw  = {pmem_read, pmem_write, pmem_address, pmem_wdata};
                cur_m    = {pmem_read, pmem_write, pmem_address, (pmem_write ? pmem_wdata : 128'h0)};
                if (exp_pm_q.size() == 0) begin
                    mem_who = 1'b0;
                    check("unexpected_pmem_req", 160'(cur_m), 160'(0));
                end else begin
                    mem_who = exp_who_q.pop_front();
                    check("pmem_req", 160'(cur_m), 160'(exp_pm_q.pop_front()));
                end
                mem_lat_cur = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
            end else begin
                check("pmem_hold", 160'({pmem_read, pmem_write, pmem_address, pmem_wdata}), 160'(mem_raw));
            end
            mem_cnt++;
            if (mem_cnt == mem_lat_cur) begin
                pmem_resp  = 1'b1;
                pmem_rdata = use_fixed ? fixed_rdata : rand_line();
                exp_rsp_q.push_back({mem_who, pmem_rdata});
            end
        end else if (stray_req) begin
            stray_req  = 1'b0;
            pmem_resp  = 1'b1;
            pmem_rdata = rand_line();
        end
    end

    // Response monitor: every cache response must match the head of the
    // expected queue; idle rdata must be zero.
    always @(negedge clk) begin
        #2;
        if (!i_resp) check("i_rdata_idle", 160'(i_rdata), 160'(0));
        if (!d_resp) check("d_rdata_idle", 160'(d_rdata), 160'(0));
        if (i_resp || d_resp) begin
            if (exp_rsp_q.size() == 0) begin
                check("unexpected_resp", 160'({i_resp, d_resp}), 160'(2'b00));
            end else begin
                logic [128:0] e;
                e = exp_rsp_q.pop_front();
                check("resp", 160'({i_resp, d_resp, (d_resp ? d_rdata : i_rdata)}),
                      160'({~e[128], e[128], e[127:0]}));
            end
        end
    end

    // Driver tasks
    task automatic drop_all();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic check_grants(input string tag);
        check({tag, "_i_grants"}, 160'(i_grants), 160'(16'(model_ic)));
        check({tag, "_d_grants"}, 160'(d_grants), 160'(16'(model_dc)));
    endtask

    task automatic flush_model();
        exp_pm_q.delete(); exp_who_q.delete(); exp_rsp_q.delete();
        model_ic = 0; model_dc = 0; model_tie_d = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drop_all();
        @(negedge clk);
        #2;
        flush_model();
        check("reset_ctrl", 160'({pmem_read, pmem_write, pmem_address, i_resp, d_resp, i_grants, d_grants, dbg_state}), 160'(0));
        check("reset_data", 160'(pmem_wdata | i_rdata | d_rdata), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_single(input logic is_d, input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [127:0] wdata,
                             input logic scr, input logic [15:0] scr_addr, input logic hold_extra);
        logic w;
        logic got;
        w = is_d & wr;
        exp_pm_q.push_back(pm_word(w, addr, wdata));
        exp_who_q.push_back(is_d);
        if (is_d) model_dc = sat16(model_dc); else model_ic = sat16(model_ic);
        @(negedge clk);
        if (is_d) begin
            d_read = rd; d_write = wr; d_address = addr; d_wdata = wdata;
        end else begin
            i_read = 1'b1; i_address = addr;
        end
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            #2;
            if (is_d ? d_resp : i_resp) got = 1'b1;
            else if (scr && (pmem_read || pmem_write)) begin
                i_address = scr_addr; d_address = scr_addr; d_wdata = rand_line();
            end
        end
        check("single_done", 160'(got), 160'(1));
        if (hold_extra) begin
            @(negedge clk);
            #2;
            check("held_release_state", 160'(dbg_state), 160'(RELEASE));
        end
        drop_all();
        check_grants("single");
    endtask

    task automatic do_pair(input logic [15:0] ia, input logic rd, input logic wr,
                           input logic [15:0] da, input logic [127:0] dw);
        logic first_d;
        logic gi;
        logic gd;
        first_d = ~model_tie_d;
        if (first_d) begin
            exp_pm_q.push_back(pm_word(wr, da, dw)); exp_who_q.push_back(1'b1);
            exp_pm_q.push_back(pm_word(1'b0, ia, 128'h0)); exp_who_q.push_back(1'b0);
        end else begin
            exp_pm_q.push_back(pm_word(1'b0, ia, 128'h0)); exp_who_q.push_back(1'b0);
            exp_pm_q.push_back(pm_word(wr, da, dw)); exp_who_q.push_back(1'b1);
        end
        model_tie_d = first_d;
        model_ic = sat16(model_ic);
        model_dc = sat16(model_dc);
        @(negedge clk);
        i_read = 1'b1; i_address = ia;
        d_read = rd; d_write = wr; d_address = da; d_wdata = dw;
        gi = 1'b0; gd = 1'b0;
        for (int k = 0; k < 300 && !(gi && gd); k++) begin
            @(negedge clk);
            #2;
            if (i_resp) begin gi = 1'b1; i_read = 1'b0; end
            if (d_resp) begin gd = 1'b1; d_read = 1'b0; d_write = 1'b0; end
        end
        check("pair_done", 160'({gi, gd}), 160'(2'b11));
        drop_all();
        check_grants("pair");
    endtask

    // Main stimulus
    initial begin
        rst_n = 1'b0; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        do_reset();

        // Single I fill, memory answers on the third strobe cycle
        mem_lat = 3; use_fixed = 1'b1; fixed_rdata = {16{8'hA5}};
        do_single(1'b0, 1'b1, 1'b0, 16'h0040, '0, 1'b0, '0, 1'b0);
        use_fixed = 1'b0;

        // D writeback
        mem_lat = 2;
        do_single(1'b1, 1'b0, 1'b1, 16'h1230, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0, '0, 1'b0);

        // Contention from a fresh reset: D then I, then I then D
        mem_lat = 0;
        do_reset();
        do_pair(16'h0100, 1'b1, 1'b0, 16'h0200, '0);
        do_pair(16'h0100, 1'b1, 1'b0, 16'h0200, '0);
        check("contention_i_grants", 160'(i_grants), 160'(16'd2));
        check("contention_d_grants", 160'(d_grants), 160'(16'd2));

        // Address changes mid-service must not reach pmem
        mem_lat = 4;
        do_single(1'b1, 1'b1, 1'b0, 16'h1230, rand_line(), 1'b1, 16'hFFF0, 1'b0);

        // Request held one cycle past its response
        mem_lat = 0;
        do_single(1'b0, 1'b1, 1'b0, 16'h0380, '0, 1'b0, '0, 1'b1);
        idle_cycles(3);
        check_grants("held");

        // Read and write together count as a write
        do_single(1'b1, 1'b1, 1'b1, 16'h0C00, rand_line(), 1'b0, '0, 1'b0);

        // Memory response while idle is ignored
        idle_cycles(2);
        stray_req = 1'b1;
        idle_cycles(4);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int kind;
            logic wr;
            logic rd;
            kind = int'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            case (kind)
                0: do_single(1'b0, 1'b1, 1'b0, 16'($urandom), '0, 1'($urandom_range(0, 1)),
                             16'($urandom), 1'($urandom_range(0, 1)));
                1: do_single(1'b1, rd, wr, 16'($urandom), rand_line(), 1'($urandom_range(0, 1)),
                             16'($urandom), 1'($urandom_range(0, 1)));
                2: do_pair(16'($urandom), rd, wr, 16'($urandom), rand_line());
                default: begin
                    idle_cycles(2);
                    stray_req = 1'b1;
                    idle_cycles(3);
                end
            endcase
        end

        // Reset in the middle of a D writeback
        mem_lat = 50;
        exp_pm_q.push_back(pm_word(1'b1, 16'h1230, 128'hFEEDFACE_CAFEBABE_0BADF00D_DEADBEEF));
        exp_who_q.push_back(1'b1);
        @(negedge clk);
        d_write = 1'b1; d_address = 16'h1230; d_wdata = 128'hFEEDFACE_CAFEBABE_0BADF00D_DEADBEEF;
        idle_cycles(3);
        #2;
        check("midop_write_strobe", 160'(pmem_write), 160'(1));
        @(negedge clk);
        rst_n = 1'b0;
        drop_all();
        @(negedge clk);
        #2;
        flush_model();
        check("midop_after_reset", 160'({pmem_read, pmem_write, i_grants, d_grants, dbg_state}), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        mem_lat = 0;
        do_single(1'b0, 1'b1, 1'b0, 16'h0440, '0, 1'b0, '0, 1'b0);
        idle_cycles(3);
        check("end_pm_queue_empty", 160'(exp_pm_q.size()), 160'(0));
        check("end_rsp_queue_empty", 160'(exp_rsp_q.size()), 160'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
